// File: rtl/fft_pkg.sv
// Shared types and default sizing for the spectrum frame scheduler.
package fft_pkg;

  localparam int NPTS_DEF    = 512;
  localparam int IDX_W_DEF   = 9;
  localparam int BEATS_DEF   = NPTS_DEF / 2;
  localparam int TIMEOUT_DEF = 4096;

  typedef logic bank_t;

  typedef enum logic [2:0] {
    IDLE,
    START,
    FEED,
    WAIT_OUT,
    DRAIN,
    DONE,
    ABORT
  } rd_state_e;

endpackage

// File: rtl/fft_frame_scheduler_if.sv
// Capture, bank-RAM, DFT handshake and detector signals of the frame scheduler.
interface fft_frame_scheduler_if #(
  parameter int IDX_W = 9
);
  logic             enable;
  logic             sample_valid;
  logic             wr_en;
  logic             wr_bank;
  logic [IDX_W-1:0] wr_addr;
  logic             rd_en;
  logic             rd_bank;
  logic [IDX_W-2:0] rd_addr;
  logic             dft_reset;
  logic             dft_next;
  logic             dft_next_out;
  logic             peak_clear;
  logic             out_valid;
  logic [IDX_W-2:0] out_index;
  logic             frame_done;
  logic             overrun;
  logic             dft_timeout;
  logic [15:0]      frame_count;

  modport master (
    input  enable, sample_valid, dft_next_out,
    output wr_en, wr_bank, wr_addr, rd_en, rd_bank, rd_addr,
           dft_reset, dft_next, peak_clear, out_valid, out_index,
           frame_done, overrun, dft_timeout, frame_count
  );

  modport slave (
    output enable, sample_valid, dft_next_out,
    input  wr_en, wr_bank, wr_addr, rd_en, rd_bank, rd_addr,
           dft_reset, dft_next, peak_clear, out_valid, out_index,
           frame_done, overrun, dft_timeout, frame_count
  );
endinterface

// File: rtl/fft_bank_writer.sv
// Ping-pong write side: sample address, bank toggle, per-bank full bits, sticky overrun.
module fft_bank_writer
  import fft_pkg::*;
#(
  parameter int NPTS  = NPTS_DEF,
  parameter int IDX_W = IDX_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_enable,
  input  logic             i_sample_valid,
  input  logic             i_release,
  input  bank_t            i_rel_bank,
  output logic             o_wr_en,
  output bank_t            o_wr_bank,
  output logic [IDX_W-1:0] o_wr_addr,
  output logic [1:0]       o_full,
  output logic             o_overrun
);

  localparam logic [IDX_W-1:0] LAST_ADDR = IDX_W'(NPTS - 1);

  bank_t            r_wr_bank;
  logic [IDX_W-1:0] r_wr_addr;
  logic [1:0]       r_full;
  logic             r_overrun;

  logic       w_rel_hit;
  logic       w_blocked;
  logic       w_drop;
  logic       w_last;
  logic [1:0] w_full_nxt;

  // A bank released this cycle already counts as empty for the incoming sample.
  assign w_rel_hit = i_release && (i_rel_bank == r_wr_bank);
  assign w_blocked = r_full[r_wr_bank] && !w_rel_hit;
  assign o_wr_en   = i_sample_valid && i_enable && !w_blocked;
  assign w_drop    = i_sample_valid && i_enable && w_blocked;
  assign w_last    = o_wr_en && (r_wr_addr == LAST_ADDR);

  always_comb begin
    w_full_nxt = r_full;
    if (i_release) w_full_nxt[i_rel_bank] = 1'b0;
    if (w_last)    w_full_nxt[r_wr_bank]  = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_bank <= 1'b0;
      r_wr_addr <= '0;
      r_full    <= 2'b00;
      r_overrun <= 1'b0;
    end else begin
      r_full <= w_full_nxt;
      if (o_wr_en) begin
        if (w_last) begin
          r_wr_addr <= '0;
          r_wr_bank <= ~r_wr_bank;
        end else begin
          r_wr_addr <= r_wr_addr + 1'b1;
        end
      end
      if (w_drop) r_overrun <= 1'b1;
    end
  end

  assign o_wr_bank = r_wr_bank;
  assign o_wr_addr = r_wr_addr;
  assign o_full    = r_full;
  assign o_overrun = r_overrun;

endmodule

// File: rtl/fft_frame_scheduler.sv
// Read-side sequencer: feeds each full bank to the DFT core, indexes its output beats,
// and reports per-frame completion, timeout and frame count.
module fft_frame_scheduler
  import fft_pkg::*;
#(
  parameter int NPTS    = NPTS_DEF,
  parameter int IDX_W   = IDX_W_DEF,
  parameter int BEATS   = BEATS_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input logic                   clk,
  input logic                   reset,
  fft_frame_scheduler_if.master bus
);

  localparam int CNT_W = ((TIMEOUT > NPTS) ? $clog2(TIMEOUT) : IDX_W) + 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT - 1);

  rd_state_e        r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_next_seen, w_next_seen_nxt;
  bank_t            r_rd_bank;
  logic [15:0]      r_frame_count;
  logic             r_timeout;
  logic             r_rst_hold;

  logic             w_start, w_rd_en, w_out_valid, w_frame_done, w_abort, w_release;
  logic             w_wr_en;
  bank_t            w_wr_bank;
  logic [IDX_W-1:0] w_wr_addr;
  logic [1:0]       w_full;
  logic             w_overrun;

  fft_bank_writer #(
    .NPTS  (NPTS),
    .IDX_W (IDX_W)
  ) u_writer (
    .clk            (clk),
    .reset          (reset),
    .i_enable       (bus.enable),
    .i_sample_valid (bus.sample_valid),
    .i_release      (w_release),
    .i_rel_bank     (r_rd_bank),
    .o_wr_en        (w_wr_en),
    .o_wr_bank      (w_wr_bank),
    .o_wr_addr      (w_wr_addr),
    .o_full         (w_full),
    .o_overrun      (w_overrun)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_next_seen   <= 1'b0;
      r_rd_bank     <= 1'b0;
      r_frame_count <= 16'd0;
      r_timeout     <= 1'b0;
      r_rst_hold    <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_next_seen <= w_next_seen_nxt;
      r_rst_hold  <= 1'b0;
      if (w_release)    r_rd_bank     <= ~r_rd_bank;
      if (w_frame_done) r_frame_count <= r_frame_count + 16'd1;
      if (r_state == WAIT_OUT && w_state_nxt == ABORT) r_timeout <= 1'b1;
    end
  end

  // r_cnt is the beat index in FEED/DRAIN, the wait timer in WAIT_OUT, the pulse length in ABORT.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_next_seen_nxt = r_next_seen;
    w_start         = 1'b0;
    w_rd_en         = 1'b0;
    w_out_valid     = 1'b0;
    w_frame_done    = 1'b0;
    w_abort         = 1'b0;
    w_release       = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_full[r_rd_bank]) begin
          w_start         = 1'b1;
          w_state_nxt     = START;
          w_cnt_nxt       = '0;
          w_next_seen_nxt = 1'b0;
        end
      end
      START: begin
        w_state_nxt     = FEED;
        w_cnt_nxt       = '0;
        w_next_seen_nxt = r_next_seen | bus.dft_next_out;
      end
      FEED: begin
        w_rd_en = 1'b1;
        if (r_cnt == LAST_BEAT) begin
          w_cnt_nxt       = '0;
          w_next_seen_nxt = 1'b0;
          w_state_nxt     = (r_next_seen || bus.dft_next_out) ? DRAIN : WAIT_OUT;
        end else begin
          w_cnt_nxt       = r_cnt + 1'b1;
          w_next_seen_nxt = r_next_seen | bus.dft_next_out;
        end
      end
      WAIT_OUT: begin
        if (bus.dft_next_out) begin
          w_state_nxt = DRAIN;
          w_cnt_nxt   = '0;
        end else if (r_cnt == LAST_WAIT) begin
          w_state_nxt = ABORT;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      DRAIN: begin
        w_out_valid = 1'b1;
        if (r_cnt == LAST_BEAT) begin
          w_state_nxt = DONE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      DONE: begin
        w_frame_done = 1'b1;
        w_release    = 1'b1;
        w_state_nxt  = IDLE;
      end
      ABORT: begin
        w_abort = 1'b1;
        if (r_cnt == CNT_W'(1)) begin
          w_release   = 1'b1;
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign bus.wr_en       = w_wr_en;
  assign bus.wr_bank     = w_wr_bank;
  assign bus.wr_addr     = w_wr_addr;
  assign bus.rd_en       = w_rd_en;
  assign bus.rd_bank     = r_rd_bank;
  assign bus.rd_addr     = w_rd_en ? r_cnt[IDX_W-2:0] : '0;
  assign bus.dft_reset   = r_rst_hold | w_abort;
  assign bus.dft_next    = w_start;
  assign bus.peak_clear  = w_start;
  assign bus.out_valid   = w_out_valid;
  assign bus.out_index   = w_out_valid ? r_cnt[IDX_W-2:0] : '0;
  assign bus.frame_done  = w_frame_done;
  assign bus.overrun     = w_overrun;
  assign bus.dft_timeout = r_timeout;
  assign bus.frame_count = r_frame_count;

endmodule

// File: tb/tb_fft_frame_scheduler.sv
// Scoreboard bench for fft_frame_scheduler with a behavioural DFT handshake model.
module tb_fft_frame_scheduler;
  import fft_pkg::*;

  localparam int NPTS    = 512;
  localparam int IDX_W   = 9;
  localparam int BEATS   = 256;
  localparam int TIMEOUT = 4096;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;

  fft_frame_scheduler_if #(.IDX_W(IDX_W)) bus ();

  fft_frame_scheduler #(
    .NPTS    (NPTS),
    .IDX_W   (IDX_W),
    .BEATS   (BEATS),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  logic [IDX_W:0]   wr_q[$];
  logic [IDX_W-1:0] rd_q[$];
  logic [IDX_W-2:0] out_q[$];
  logic [16:0]      done_q[$];

  int t_wr_last = -1, t_next = -1, t_nextout = -1, t_first_out = -1;
  int t_last_out = -1, t_last_rd = -1, t_done = -1;
  bit dft_stall = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    checks++;
    failures++;
    $display("FAIL %s: unexpected event value 0x%0h, expected none", name, act);
  endtask

  task automatic push_wr(input logic b, input int first, input int n);
    for (int i = first; i < first + n; i++) wr_q.push_back({b, IDX_W'(i)});
  endtask

  task automatic push_frame(input logic b, input int n_out, input bit with_done, input int fc);
    for (int k = 0; k < BEATS; k++) rd_q.push_back({b, (IDX_W-1)'(k)});
    for (int k = 0; k < n_out; k++) out_q.push_back((IDX_W-1)'(k));
    if (with_done) done_q.push_back({b, 16'(fc)});
  endtask

  // gap idle cycles follow each strobe; gap=0 is a continuous burst
  task automatic strobe(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); bus.sample_valid = 1'b1;
      for (int g = 0; g < gap; g++) begin
        @(negedge clk); bus.sample_valid = 1'b0;
      end
    end
    @(negedge clk); bus.sample_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int n = 0;
    do begin
      @(negedge clk); n++;
    end while (!bus.frame_done && n < budget);
    if (!bus.frame_done) begin
      checks++; failures++;
      $display("FAIL %s: frame_done not seen within %0d cycles", name, budget);
    end
  endtask

  // Monitor: every output event pops the matching expectation.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk); #1;
      if (!reset) begin
        if (bus.wr_en) begin
          if (wr_q.size() == 0) unexpected("wr_event", 32'({bus.wr_bank, bus.wr_addr}));
          else begin
            e = 32'(wr_q.pop_front());
            chk("wr_bank_addr", 32'({bus.wr_bank, bus.wr_addr}), e);
          end
          if (bus.wr_addr == IDX_W'(NPTS - 1)) t_wr_last = cyc;
        end
        if (bus.rd_en) begin
          if (rd_q.size() == 0) unexpected("rd_event", 32'({bus.rd_bank, bus.rd_addr}));
          else begin
            e = 32'(rd_q.pop_front());
            chk("rd_bank_addr", 32'({bus.rd_bank, bus.rd_addr}), e);
          end
          t_last_rd = cyc;
        end
        if (bus.out_valid) begin
          if (out_q.size() == 0) unexpected("out_event", 32'(bus.out_index));
          else begin
            e = 32'(out_q.pop_front());
            chk("out_index", 32'(bus.out_index), e);
          end
          if (bus.out_index == '0) t_first_out = cyc;
          t_last_out = cyc;
        end
        if (bus.frame_done) begin
          if (done_q.size() == 0) unexpected("frame_done", 32'({bus.rd_bank, bus.frame_count}));
          else begin
            e = 32'(done_q.pop_front());
            chk("done_bank_count", 32'({bus.rd_bank, bus.frame_count}), e);
          end
          t_done = cyc;
        end
        if (bus.dft_next) t_next = cyc;
      end
    end
  end

  // DFT model: first output 40 cycles after the last feed beat unless stalled.
  initial begin
    bus.dft_next_out = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset && !dft_stall && bus.rd_en && bus.rd_addr == (IDX_W-1)'(BEATS - 1)) begin
        repeat (40) @(negedge clk);
        bus.dft_next_out = 1'b1;
        t_nextout = cyc;
        @(negedge clk);
        bus.dft_next_out = 1'b0;
      end
    end
  end

  initial begin
    int n;
    int t_rise;
    bus.enable = 1'b1;
    bus.sample_valid = 1'b0;
    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_wr_en",       32'(bus.wr_en), 32'd0);
    chk("rst_wr_bank",     32'(bus.wr_bank), 32'd0);
    chk("rst_wr_addr",     32'(bus.wr_addr), 32'd0);
    chk("rst_rd_bank",     32'(bus.rd_bank), 32'd0);
    chk("rst_rd_en",       32'(bus.rd_en), 32'd0);
    chk("rst_out_valid",   32'(bus.out_valid), 32'd0);
    chk("rst_dft_next",    32'(bus.dft_next), 32'd0);
    chk("rst_frame_count", 32'(bus.frame_count), 32'd0);
    chk("rst_overrun",     32'(bus.overrun), 32'd0);
    chk("rst_timeout",     32'(bus.dft_timeout), 32'd0);
    chk("rst_dft_reset",   32'(bus.dft_reset), 32'd1);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk); chk("dft_reset_hold", 32'(bus.dft_reset), 32'd1);
    @(negedge clk); chk("dft_reset_off",  32'(bus.dft_reset), 32'd0);

    // Single frame on bank 0, sparse strobes
    push_wr(1'b0, 0, NPTS);
    push_frame(1'b0, BEATS, 1'b1, 0);
    strobe(NPTS, 3);
    wait_done(2000, "p1_done");
    @(negedge clk);
    chk("p1_frame_count", 32'(bus.frame_count), 32'd1);
    chk("p1_rd_bank",     32'(bus.rd_bank), 32'd1);
    chk("p1_wr_bank",     32'(bus.wr_bank), 32'd1);
    chk("p1_next_latency",     32'(t_next - t_wr_last), 32'd1);
    chk("p1_nextout_delay",    32'(t_nextout - t_last_rd), 32'd40);
    chk("p1_first_out_lat",    32'(t_first_out - t_nextout), 32'd1);
    chk("p1_done_latency",     32'(t_done - t_last_out), 32'd1);

    // Both banks back to back, then bank 1 refill finishing on bank 0's DONE
    push_wr(1'b1, 0, NPTS);
    push_wr(1'b0, 0, NPTS);
    push_frame(1'b1, BEATS, 1'b1, 1);
    push_frame(1'b0, BEATS, 1'b1, 2);
    strobe(2 * NPTS, 0);
    wait_done(3000, "p2_done_bank1");
    @(negedge clk);
    push_wr(1'b1, 0, NPTS - 1);
    strobe(NPTS - 1, 0);
    chk("p2_wr_addr_pre", 32'(bus.wr_addr), 32'(NPTS - 1));
    push_wr(1'b1, NPTS - 1, 1);
    wait_done(1000, "p2_done_bank0");
    bus.sample_valid = 1'b1;
    push_frame(1'b1, 100, 1'b0, 0);
    @(negedge clk);
    bus.sample_valid = 1'b0;
    chk("p2_wr_bank",     32'(bus.wr_bank), 32'd0);
    chk("p2_wr_addr",     32'(bus.wr_addr), 32'd0);
    chk("p2_overrun",     32'(bus.overrun), 32'd0);
    chk("p2_frame_count", 32'(bus.frame_count), 32'd3);

    // Asynchronous reset in the middle of DRAIN
    n = 0;
    do begin
      @(negedge clk); n++;
    end while (!(bus.out_valid && bus.out_index == (IDX_W-1)'(99)) && n < 2000);
    chk("p3_reached_drain", 32'(bus.out_valid), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("p3_out_valid",   32'(bus.out_valid), 32'd0);
    chk("p3_out_index",   32'(bus.out_index), 32'd0);
    chk("p3_rd_bank",     32'(bus.rd_bank), 32'd0);
    chk("p3_wr_bank",     32'(bus.wr_bank), 32'd0);
    chk("p3_frame_count", 32'(bus.frame_count), 32'd0);
    chk("p3_dft_reset",   32'(bus.dft_reset), 32'd1);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk); chk("p3_dft_reset_hold", 32'(bus.dft_reset), 32'd1);
    @(negedge clk); chk("p3_dft_reset_off",  32'(bus.dft_reset), 32'd0);
    push_wr(1'b0, 0, NPTS);
    push_frame(1'b0, BEATS, 1'b1, 0);
    strobe(NPTS, 0);
    wait_done(2000, "p3_done");
    @(negedge clk);
    chk("p3_frame_count_after", 32'(bus.frame_count), 32'd1);

    // Stalled DFT: overrun on the 1025th sample, then timeout/abort
    dft_stall = 1'b1;
    push_wr(1'b1, 0, NPTS);
    push_wr(1'b0, 0, NPTS);
    push_frame(1'b1, 0, 1'b0, 0);
    strobe(2 * NPTS + 1, 0);
    chk("p4_overrun", 32'(bus.overrun), 32'd1);
    chk("p4_wr_addr", 32'(bus.wr_addr), 32'd0);
    n = 0;
    do begin
      @(negedge clk); n++;
    end while (!bus.dft_reset && n < 6000);
    chk("p4_abort_seen", 32'(bus.dft_reset), 32'd1);
    t_rise = cyc;
    dft_stall = 1'b0;
    push_frame(1'b0, BEATS, 1'b1, 1);
    chk("p4_timeout_len", 32'(t_rise - t_last_rd), 32'(TIMEOUT + 1));
    chk("p4_timeout_flag", 32'(bus.dft_timeout), 32'd1);
    n = 0;
    while (bus.dft_reset && n < 10) begin
      n++; @(negedge clk);
    end
    chk("p4_dft_reset_len", 32'(n), 32'd2);
    chk("p4_rd_bank_after_abort", 32'(bus.rd_bank), 32'd0);
    wait_done(2000, "p4_done");
    @(negedge clk);
    chk("p4_frame_count", 32'(bus.frame_count), 32'd2);
    chk("p4_overrun_held", 32'(bus.overrun), 32'd1);
    chk("p4_timeout_held", 32'(bus.dft_timeout), 32'd1);
    chk("p4_rd_bank", 32'(bus.rd_bank), 32'd1);

    repeat (5) @(negedge clk);
    chk("left_wr",   32'(wr_q.size()), 32'd0);
    chk("left_rd",   32'(rd_q.size()), 32'd0);
    chk("left_out",  32'(out_q.size()), 32'd0);
    chk("left_done", 32'(done_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
